// File: rtl/cell_test_pkg.sv
// Shared types and defaults for the standard-cell test sequencer.
package cell_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_N_OUT  = 2;
    localparam int DEF_SETTLE = 4;
    localparam int DEF_ERR_W  = 16;

    // Last vector of a sweep over n inputs.
    function automatic logic [31:0] term_vec(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/cell_test_sync.sv
// Two-flop synchronizer for the asynchronous cell response lanes.
module cell_test_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/cell_test_sequencer.sv
// Exhaustive vector sweep, settle, sample and compare engine for one cell.
// Optional continuous re-sweep enabled by defining CELL_TEST_SEQ_LOOP_EN.
module cell_test_sequencer
    import cell_test_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
`ifdef CELL_TEST_SEQ_LOOP_EN
    input  logic                        loop_i,
`endif
    input  logic [$clog2(N_IN+1)-1:0]   n_inputs_i,
    input  logic [N_OUT-1:0]            out_mask_i,
    input  logic [(2**N_IN)*N_OUT-1:0]  exp_tbl_i,
    output logic [N_IN-1:0]             stim_o,
    input  logic [N_OUT-1:0]            resp_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [ERR_W-1:0]            err_cnt_o,
    output logic [N_IN-1:0]             fail_vec_o,
    output logic                        fail_valid_o
);

    localparam int NEFF_W = $clog2(N_IN + 1);
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   vec_reg, vec_next;
    logic [N_IN-1:0]   stim_reg, stim_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NEFF_W-1:0] n_eff_reg, n_eff_next;
    logic [ERR_W-1:0]  err_reg, err_next;
    logic [N_IN-1:0]   fail_vec_reg, fail_vec_next;
    logic              fail_valid_reg, fail_valid_next;
    logic              pass_reg, pass_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic [N_OUT-1:0]  resp_sync;
    logic [N_OUT-1:0]  exp_arr [2**N_IN];
    logic [N_OUT-1:0]  exp_bits;
    logic              mismatch;
    logic [ERR_W-1:0]  err_inc;
    logic [ERR_W-1:0]  err_final;
    logic [N_IN-1:0]   term;
    logic [NEFF_W-1:0] n_clamped;
    logic              loop_req;

    cell_test_sync #(.W(N_OUT)) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (resp_i),
        .q     (resp_sync)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2**N_IN; gi++) begin : g_exp
            assign exp_arr[gi] = exp_tbl_i[gi*N_OUT +: N_OUT];
        end
    endgenerate

`ifdef CELL_TEST_SEQ_LOOP_EN
    assign loop_req = loop_i;
`else
    assign loop_req = 1'b0;
`endif

    assign exp_bits  = exp_arr[vec_reg];
    assign mismatch  = |((resp_sync ^ exp_bits) & out_mask_i);
    assign err_inc   = (err_reg == '1) ? err_reg : err_reg + 1'b1;
    assign err_final = mismatch ? err_inc : err_reg;
    assign term      = N_IN'(term_vec(int'(n_eff_reg)));
    assign n_clamped = (n_inputs_i > NEFF_W'(N_IN)) ? NEFF_W'(N_IN) : n_inputs_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= ST_IDLE;
            vec_reg        <= '0;
            stim_reg       <= '0;
            cnt_reg        <= '0;
            n_eff_reg      <= '0;
            err_reg        <= '0;
            fail_vec_reg   <= '0;
            fail_valid_reg <= 1'b0;
            pass_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vec_reg        <= vec_next;
            stim_reg       <= stim_next;
            cnt_reg        <= cnt_next;
            n_eff_reg      <= n_eff_next;
            err_reg        <= err_next;
            fail_vec_reg   <= fail_vec_next;
            fail_valid_reg <= fail_valid_next;
            pass_reg       <= pass_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        vec_next        = vec_reg;
        stim_next       = stim_reg;
        cnt_next        = cnt_reg;
        n_eff_next      = n_eff_reg;
        err_next        = err_reg;
        fail_vec_next   = fail_vec_reg;
        fail_valid_next = fail_valid_reg;
        pass_next       = pass_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next      = ST_SETTLE;
                    vec_next        = '0;
                    stim_next       = '0;
                    err_next        = '0;
                    fail_valid_next = 1'b0;
                    pass_next       = 1'b0;
                    n_eff_next      = n_clamped;
                    cnt_next        = CNT_W'(SETTLE - 1);
                    busy_next       = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                err_next = err_final;
                if (mismatch && !fail_valid_reg) begin
                    fail_vec_next   = vec_reg;
                    fail_valid_next = 1'b1;
                end
                if (vec_reg == term) begin
                    done_next = 1'b1;
                    pass_next = (err_final == '0);
                    if (loop_req) begin
                        // Re-sweep in place; errors keep accumulating.
                        state_next = ST_SETTLE;
                        vec_next   = '0;
                        stim_next  = '0;
                        cnt_next   = CNT_W'(SETTLE - 1);
                    end else begin
                        state_next = ST_DONE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    state_next = ST_SETTLE;
                    vec_next   = vec_reg + 1'b1;
                    stim_next  = vec_reg + 1'b1;
                    cnt_next   = CNT_W'(SETTLE - 1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything, leaving the partial results visible.
        if (abort_i) begin
            state_next      = ST_IDLE;
            stim_next       = '0;
            busy_next       = 1'b0;
            done_next       = 1'b0;
            pass_next       = 1'b0;
            err_next        = err_reg;
            fail_vec_next   = fail_vec_reg;
            fail_valid_next = fail_valid_reg;
        end
    end

    assign stim_o       = stim_reg;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign pass_o       = pass_reg;
    assign err_cnt_o    = err_reg;
    assign fail_vec_o   = fail_vec_reg;
    assign fail_valid_o = fail_valid_reg;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Directed bench for cell_test_sequencer with behavioural cell models.
module tb_cell_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loop = 1'b0;
    logic [2:0]  n_inputs = 3'd0;
    logic [1:0]  out_mask = 2'b00;
    logic [31:0] exp_tbl = 32'h0;
    logic [1:0]  resp;
    logic [3:0]  stim, stim2;
    logic        busy, done, pass, fail_valid;
    logic [15:0] err_cnt;
    logic [3:0]  fail_vec;
    logic        busy2, done2, pass2, fail_valid2;
    logic [1:0]  err_cnt2;
    logic [3:0]  fail_vec2;
    int          mode = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  max_stim;

    always #5 clk = ~clk;

    // 0: NAND2 good, 1: stuck-at-0, 2: HAX1 with YC flipped at vec 3
    always_comb begin
        case (mode)
            0:       resp = {1'b0, ~(stim[0] & stim[1])};
            1:       resp = 2'b00;
            default: resp = {(stim[0] & stim[1]) ^ (stim == 4'd3), stim[0] ^ stim[1]};
        endcase
    end

    cell_test_sequencer #(.N_IN(4), .N_OUT(2), .SETTLE(4), .ERR_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
`ifdef CELL_TEST_SEQ_LOOP_EN
        .loop_i(loop),
`endif
        .n_inputs_i(n_inputs), .out_mask_i(out_mask), .exp_tbl_i(exp_tbl),
        .stim_o(stim), .resp_i(resp), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_cnt_o(err_cnt), .fail_vec_o(fail_vec), .fail_valid_o(fail_valid)
    );

    cell_test_sequencer #(.N_IN(4), .N_OUT(2), .SETTLE(4), .ERR_W(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
`ifdef CELL_TEST_SEQ_LOOP_EN
        .loop_i(loop),
`endif
        .n_inputs_i(n_inputs), .out_mask_i(out_mask), .exp_tbl_i(exp_tbl),
        .stim_o(stim2), .resp_i(resp), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .err_cnt_o(err_cnt2), .fail_vec_o(fail_vec2), .fail_valid_o(fail_valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic run_sweep(input string tag, input int exp_lat);
        int cyc;
        cyc = 0;
        max_stim = 4'd0;
        @(negedge clk);
        start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (stim > max_stim) max_stim = stim;
            if (cyc == 2) check({tag, "_busy"}, 32'(busy), 32'd1);
        end while (!done && cyc < 400);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        $display("sweep %s: latency=%0d err=%0d pass=%0b fail_vec=%0d fail_valid=%0b",
                 tag, cyc, err_cnt, pass, fail_vec, fail_valid);
    endtask

    initial begin
        int pulses;
        #2;
        check("reset_stim", 32'(stim), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err", 32'(err_cnt), 32'd0);
        check("reset_fvalid", 32'(fail_valid), 32'd0);
        check("reset_fvec", 32'(fail_vec), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // NAND2 good model
        mode = 0; n_inputs = 3'd2; out_mask = 2'b01; exp_tbl = 32'h15;
        run_sweep("nand_good", 21);
        check("nand_good_pass", 32'(pass), 32'd1);
        check("nand_good_err", 32'(err_cnt), 32'd0);
        check("nand_good_fvalid", 32'(fail_valid), 32'd0);
        check("nand_good_stim_max", 32'(max_stim), 32'd3);
        @(negedge clk);
        check("nand_good_done_pulse", 32'(done), 32'd0);
        check("nand_good_pass_hold", 32'(pass), 32'd1);

        // Stuck-at-0
        mode = 1;
        run_sweep("nand_stuck", 21);
        check("nand_stuck_err", 32'(err_cnt), 32'd3);
        check("nand_stuck_fvec", 32'(fail_vec), 32'd0);
        check("nand_stuck_fvalid", 32'(fail_valid), 32'd1);
        check("nand_stuck_pass", 32'(pass), 32'd0);

        // HAX1 with YC flipped at vec 3
        mode = 2; out_mask = 2'b11; exp_tbl = 32'h94;
        run_sweep("hax1_flip", 21);
        check("hax1_err", 32'(err_cnt), 32'd1);
        check("hax1_fvec", 32'(fail_vec), 32'd3);
        check("hax1_fvalid", 32'(fail_valid), 32'd1);

        // Abort during SETTLE of vec 2 with a failing model
        mode = 1; out_mask = 2'b01; exp_tbl = 32'h15;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_pre_stim", 32'(stim), 32'd2);
        check("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_stim", 32'(stim), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_err_partial", 32'(err_cnt), 32'd2);
        check("abort_fvec_partial", 32'(fail_vec), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        $display("abort: err=%0d busy=%0b", err_cnt, busy);

        // n_inputs clamped to 4: 16 vectors, 16 errors, narrow counter saturates
        n_inputs = 3'd7; exp_tbl = 32'h5555_5555;
        run_sweep("clamp", 81);
        check("clamp_stim_max", 32'(max_stim), 32'd15);
        check("clamp_err", 32'(err_cnt), 32'd16);
        check("clamp_err_sat", 32'(err_cnt2), 32'd3);
        check("clamp_done2", 32'(done2), 32'd1);

        // Single vector
        mode = 0; n_inputs = 3'd0; exp_tbl = 32'h15;
        run_sweep("single", 6);
        check("single_pass", 32'(pass), 32'd1);
        check("single_stim_max", 32'(max_stim), 32'd0);

`ifdef CELL_TEST_SEQ_LOOP_EN
        // Three looped passes, two errors per pass
        mode = 1; n_inputs = 3'd2; exp_tbl = 32'h05; loop = 1'b1;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 300 && pulses < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 2) loop = 1'b0;
            end
        end
        check("loop_pulses", 32'(pulses), 32'd3);
        check("loop_err", 32'(err_cnt), 32'd6);
        check("loop_err_sat", 32'(err_cnt2), 32'd3);
        check("loop_pass", 32'(pass), 32'd0);
        $display("loop: pulses=%0d err=%0d", pulses, err_cnt);
`endif

        // Asynchronous reset mid-sweep
        mode = 1; n_inputs = 3'd2; out_mask = 2'b01; exp_tbl = 32'h15;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_err", 32'(err_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_err", 32'(err_cnt), 32'd0);
        check("rst_mid_stim", 32'(stim), 32'd0);
        check("rst_mid_fvalid", 32'(fail_valid), 32'd0);
        $display("mid-sweep reset: busy=%0b err=%0d", busy, err_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_test_sequencer.md
Name: cell_test_sequencer

Overview:
- Stimulus/response engine for the test-wafer standard-cell bank. Each cell in the bank is a passive, pin-level cell with inputs and outputs.
- The sequencer drives an exhaustive input-vector sweep into one selected cell's inputs, waits a settle interval, and samples the cell outputs back.
- Each sample is compared against a supplied truth table. Mismatches are counted and the first failing vector is recorded.
- It sits between the Wishbone/logic-analyzer control registers and the cell-under-test mux.

Parameters:
- N_IN, 4, maximum cell inputs driven (covers AOI22/OAI22).
- N_OUT, 2, maximum cell outputs sampled (covers HAX1 YS/YC).
- SETTLE, 4, cycles between applying a vector and sampling; must be >= 3 (2 synchronizer stages + 1).
- ERR_W, 16, width of the mismatch counter.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin sweep; sampled only in IDLE.
- abort_i  in  1  cancel sweep; any state returns to IDLE.
- n_inputs_i  in  $clog2(N_IN+1)  inputs used by the cell; values > N_IN are clamped to N_IN.
- out_mask_i  in  N_OUT  output lanes to compare (1 = compare).
- exp_tbl_i  in  (2**N_IN)*N_OUT  expected outputs; vector v occupies bits [v*N_OUT +: N_OUT].
- stim_o  out  N_IN  cell input drive.
- resp_i  in  N_OUT  raw cell outputs, asynchronous to wb_clk_i.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse at sweep completion.
- pass_o  out  1  last completed sweep had zero mismatches.
- err_cnt_o  out  ERR_W  mismatch count of current/last sweep.
- fail_vec_o  out  N_IN  first failing vector.
- fail_valid_o  out  1  fail_vec_o is meaningful.

Behaviour:
- Reset values:
  - state = IDLE.
  - stim_o = 0, busy_o = 0, done_o = 0, pass_o = 0.
  - err_cnt_o = 0, fail_vec_o = 0, fail_valid_o = 0.
  - Synchronizer flops = 0.
- resp_i passes through a 2-flop synchronizer (resp_sync) before any comparison.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start_i=1 -> SETTLE.
  - On that transition: vec=0, stim_o=0, err_cnt=0, fail_valid=0, pass_o=0, settle counter loaded with SETTLE-1, busy_o=1.
- SETTLE:
  - Counter decrements each cycle.
  - At counter==0 -> SAMPLE.
- SAMPLE (one cycle):
  - mismatch = |((resp_sync ^ exp_tbl_i[vec*N_OUT +: N_OUT]) & out_mask_i).
  - On mismatch: err_cnt increments, saturating at all-ones.
  - On mismatch with fail_valid=0: fail_vec=vec and fail_valid=1.
  - If vec == 2**n_eff - 1 -> DONE.
  - Otherwise vec increments, stim_o=vec+1, counter reloads SETTLE-1 -> SETTLE.
- DONE (one cycle):
  - done_o=1, pass_o=(err_cnt==0 after the final compare), busy_o drops to 0 -> IDLE.
  - pass_o, err_cnt_o, fail_* hold until the next start.
- Latency: start accepted at cycle t -> done_o at t + 1 + (2**n_eff)*(SETTLE+1).
- n_inputs_i = 0: a single vector (0) is tested.
- n_inputs_i is latched at start; mid-sweep changes are ignored.
- out_mask_i and exp_tbl_i are read live; software holds them stable while busy_o=1.
- start_i while busy is ignored.
- abort_i has priority over start_i and over every transition:
  - Next state is IDLE, stim_o=0, busy_o=0, no done_o pulse, pass_o=0.
  - err_cnt_o and fail_* keep their partial values.
- Upper stim_o bits above n_eff are always 0.
- Reset asserted mid-sweep clears everything asynchronously; no done_o pulse.

Optional Feature:
- Macro: CELL_TEST_SEQ_LOOP_EN.
- Defined: adds input loop_i.
  - When loop_i=1 at the final SAMPLE, the sequencer pulses done_o for one cycle (in parallel with the restart), restarts at vec=0, and goes to SETTLE without passing through IDLE or clearing err_cnt/fail_*. Errors accumulate across passes.
  - pass_o updates on each done_o.
  - Sweeps stop only when loop_i=0 at the end of a pass, or on abort_i.
- Not defined: no loop_i port; behaviour exactly as above.

Decomposition:
- Package cell_test_pkg holds:
  - State enum (IDLE, SETTLE, SAMPLE, DONE).
  - Default parameter constants.
  - A function returning the 2**n_eff - 1 terminal vector.
- One sub-module: cell_test_sync, an N_OUT-wide 2-flop synchronizer with async active-low reset.

Test Plan:
- NAND2 good model (resp0 = ~(stim0&stim1)), n_inputs=2, mask=2'b01, exp lane0 per vec = 1,1,1,0 -> done_o at t+1+4*5=t+21, pass_o=1, err_cnt=0, fail_valid=0.
- Same setup with model stuck-at-0 -> err_cnt=3, fail_vec=0, fail_valid=1, pass_o=0.
- HAX1 model, n_inputs=2, mask=2'b11, exp {YC,YS} = 00,01,01,10; flip YC at vec3 only -> err_cnt=1, fail_vec=3.
- abort_i asserted in SETTLE of vec 2 -> IDLE next cycle, stim_o=0, busy_o=0, no done_o, pass_o=0.
- n_inputs=7 with N_IN=4 -> clamped, 16 vectors, done at t+81; n_inputs=0 -> one vector, done at t+6.
- CELL_TEST_SEQ_LOOP_EN, loop_i=1 for 3 passes with a failing model (2 errors/pass) -> err_cnt=6, three done_o pulses; ERR_W=2 build saturates at 3.
